// File: rtl/fp_align_if.sv
// fp_align_if: operand/result bundle for the fp_align exponent-alignment stage.
//   in_valid/in_ready   : operand handshake (a, b, op)
//   a, b                : IEEE-754 single-precision operands
//   op                  : 0 = a+b, 1 = a-b
//   out_valid/out_ready : result handshake
//   nonshifted_val      : hidden bit + fraction of the larger-magnitude operand
//   shifted_val         : hidden bit + fraction of the smaller operand, aligned
//   exponent_temp       : effective exponent of the larger operand
//   sel2                : 0 = magnitude add, 1 = magnitude subtract
//   sign                : sign of the larger operand (op already applied to b)
//   special             : an operand is Inf/NaN (exponent 0xFF)
// Modport slave is the alignment block; modport master is the surrounding logic.
interface fp_align_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        op;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] nonshifted_val;
  logic [23:0] shifted_val;
  logic [7:0]  exponent_temp;
  logic        sel2;
  logic        sign;
  logic        special;

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, nonshifted_val, shifted_val, exponent_temp, sel2, sign,
           special
  );

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, nonshifted_val, shifted_val, exponent_temp, sel2, sign,
           special
  );
endinterface

// File: rtl/fp_align.sv
// fp_align: aligns two single-precision operands ahead of a mantissa adder.
// Accepts one pair in IDLE, picks the larger magnitude in COMPARE, shifts the
// smaller mantissa right by up to 4 bits per cycle in SHIFT, and holds the
// result in DONE until the downstream stage takes it.
// Ports:
//   clk  : rising-edge clock
//   rstn : synchronous active-low reset
//   bus  : fp_align_if.slave (operand and result handshakes, see interface)
module fp_align (
  input logic       clk,
  input logic       rstn,
  fp_align_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StCompare, StShift, StDone} state_e;

  state_e state_q, state_d;

  // Unpacked operand fields, captured on accept
  logic [7:0]  exp_a_q, exp_b_q;
  logic [23:0] man_a_q, man_b_q;
  logic        sign_a_q, sign_b_q;

  // Result registers driving the outputs
  logic [23:0] nonshifted_q, shifted_q;
  logic [7:0]  exponent_q;
  logic        sel2_q, sign_q, special_q;

  // Remaining shift distance while in SHIFT
  logic [7:0]  rem_q;

  // Input unpacking
  logic [7:0]  exp_a_raw, exp_b_raw;
  logic [7:0]  exp_a_eff, exp_b_eff;
  logic        special_in;
  logic        accept;

  assign exp_a_raw  = bus.a[30:23];
  assign exp_b_raw  = bus.b[30:23];
  // Denormals use exponent 1 with no hidden bit
  assign exp_a_eff  = (exp_a_raw == 8'd0) ? 8'd1 : exp_a_raw;
  assign exp_b_eff  = (exp_b_raw == 8'd0) ? 8'd1 : exp_b_raw;
  assign special_in = (&exp_a_raw) | (&exp_b_raw);
  assign accept     = (state_q == StIdle) && bus.in_valid;

  // Magnitude comparison; a wins an exact tie
  logic        a_larger;
  logic [7:0]  exp_diff;
  logic        diff_far;

  assign a_larger = {exp_a_q, man_a_q} >= {exp_b_q, man_b_q};
  assign exp_diff = a_larger ? (exp_a_q - exp_b_q) : (exp_b_q - exp_a_q);
  // Everything is shifted out once the distance reaches the mantissa width
  assign diff_far = exp_diff >= 8'd24;

  // Per-cycle shift step: min(4, remaining)
  logic [7:0]  step;
  logic [7:0]  rem_next;

  assign step     = (rem_q > 8'd4) ? 8'd4 : rem_q;
  assign rem_next = rem_q - step;

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) state_d = StCompare;
      end
      StCompare: begin
        if ((exp_diff == 8'd0) || diff_far) state_d = StDone;
        else                                state_d = StShift;
      end
      StShift: begin
        if (rem_next == 8'd0) state_d = StDone;
      end
      StDone: begin
        if (bus.out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    unique case (state_q)
      StIdle:  bus.in_ready  = 1'b1;
      StDone:  bus.out_valid = 1'b1;
      default: ;
    endcase
  end

  // Datapath
  always_ff @(posedge clk) begin
    if (!rstn) begin
      exp_a_q      <= 8'd0;
      exp_b_q      <= 8'd0;
      man_a_q      <= 24'd0;
      man_b_q      <= 24'd0;
      sign_a_q     <= 1'b0;
      sign_b_q     <= 1'b0;
      nonshifted_q <= 24'd0;
      shifted_q    <= 24'd0;
      exponent_q   <= 8'd0;
      sel2_q       <= 1'b0;
      sign_q       <= 1'b0;
      special_q    <= 1'b0;
      rem_q        <= 8'd0;
    end else begin
      case (state_q)
        StIdle: begin
          if (accept) begin
            exp_a_q   <= exp_a_eff;
            exp_b_q   <= exp_b_eff;
            man_a_q   <= {(exp_a_raw != 8'd0), bus.a[22:0]};
            man_b_q   <= {(exp_b_raw != 8'd0), bus.b[22:0]};
            sign_a_q  <= bus.a[31];
            sign_b_q  <= bus.b[31] ^ bus.op;
            special_q <= special_in;
          end
        end
        StCompare: begin
          sel2_q       <= sign_a_q ^ sign_b_q;
          sign_q       <= a_larger ? sign_a_q : sign_b_q;
          exponent_q   <= a_larger ? exp_a_q : exp_b_q;
          nonshifted_q <= a_larger ? man_a_q : man_b_q;
          shifted_q    <= diff_far ? 24'd0 : (a_larger ? man_b_q : man_a_q);
          rem_q        <= exp_diff;
        end
        StShift: begin
          // Shifted-out bits are simply dropped
          shifted_q <= shifted_q >> step;
          rem_q     <= rem_next;
        end
        default: ;
      endcase
    end
  end

  assign bus.nonshifted_val = nonshifted_q;
  assign bus.shifted_val    = shifted_q;
  assign bus.exponent_temp  = exponent_q;
  assign bus.sel2           = sel2_q;
  assign bus.sign           = sign_q;
  assign bus.special        = special_q;

endmodule

// File: tb/tb_fp_align.sv
// Directed bench for fp_align with hand-computed expected values.
module tb_fp_align;

  logic clk;
  logic rstn;
  int   checks;
  int   passes;
  int   fails;
  int   lat;
  int   seen_valid;

  fp_align_if bus ();

  fp_align dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) passes = passes + 1;
    else begin
      fails = fails + 1;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present one pair, return edges from the accept edge until out_valid is seen
  task automatic run(input logic [31:0] a, input logic [31:0] b, input logic op,
                     output int latency);
    @(negedge clk);
    bus.a        = a;
    bus.b        = b;
    bus.op       = op;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    latency = 0;
    while (bus.out_valid !== 1'b1 && latency < 40) begin
      @(posedge clk);
      #1;
      latency = latency + 1;
    end
  endtask

  task automatic chk_result(input string tag, input logic [23:0] ns, input logic [23:0] sh,
                            input logic [7:0] ex, input logic s2, input logic sg,
                            input logic sp);
    chk({tag, ".nonshifted"}, {8'd0, bus.nonshifted_val}, {8'd0, ns});
    chk({tag, ".shifted"},    {8'd0, bus.shifted_val},    {8'd0, sh});
    chk({tag, ".exponent"},   {24'd0, bus.exponent_temp}, {24'd0, ex});
    chk({tag, ".sel2"},       {31'd0, bus.sel2},          {31'd0, s2});
    chk({tag, ".sign"},       {31'd0, bus.sign},          {31'd0, sg});
    chk({tag, ".special"},    {31'd0, bus.special},       {31'd0, sp});
  endtask

  task automatic release_result(input string tag);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk({tag, ".out_valid_fall"}, {31'd0, bus.out_valid}, 32'd0);
    chk({tag, ".in_ready_back"},  {31'd0, bus.in_ready},  32'd1);
  endtask

  initial begin
    checks        = 0;
    passes        = 0;
    fails         = 0;
    rstn          = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a         = 32'd0;
    bus.b         = 32'd0;
    bus.op        = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst.in_ready",  {31'd0, bus.in_ready},  32'd1);
    chk_result("rst", 24'h0, 24'h0, 8'h00, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rstn = 1'b1;

    // 3.0 + 1.0, d=1
    run(32'h4040_0000, 32'h3F80_0000, 1'b0, lat);
    chk("add31.latency", lat, 32'd2);
    chk_result("add31", 24'hC00000, 24'h400000, 8'h80, 1'b0, 1'b0, 1'b0);
    release_result("add31");

    // 1.0 - 1.0, d=0, tie goes to a
    run(32'h3F80_0000, 32'h3F80_0000, 1'b1, lat);
    chk("sub11.latency", lat, 32'd1);
    chk_result("sub11", 24'h800000, 24'h800000, 8'h7F, 1'b1, 1'b0, 1'b0);
    release_result("sub11");

    // 512.0 + 1.0, d=9: three SHIFT cycles
    run(32'h4400_0000, 32'h3F80_0000, 1'b0, lat);
    chk("d9.latency", lat, 32'd4);
    chk_result("d9", 24'h800000, 24'h004000, 8'h88, 1'b0, 1'b0, 1'b0);
    release_result("d9");

    // d=23: last distance that still shifts, six SHIFT cycles
    run(32'h4B00_0000, 32'h3F80_0000, 1'b0, lat);
    chk("d23.latency", lat, 32'd7);
    chk_result("d23", 24'h800000, 24'h000001, 8'h96, 1'b0, 1'b0, 1'b0);
    release_result("d23");

    // d=24, b larger: shifted forced to 0; then stall in DONE
    run(32'h3F80_0000, 32'h4B80_0000, 1'b0, lat);
    chk("d24.latency", lat, 32'd1);
    chk_result("d24", 24'h800000, 24'h000000, 8'h97, 1'b0, 1'b0, 1'b0);
    bus.a        = 32'h4040_0000;
    bus.b        = 32'hC000_0000;
    bus.op       = 1'b1;
    bus.in_valid = 1'b1;
    repeat (5) begin
      @(posedge clk);
      #1;
      chk("stall.out_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("stall.in_ready",  {31'd0, bus.in_ready},  32'd0);
    end
    chk_result("stall", 24'h800000, 24'h000000, 8'h97, 1'b0, 1'b0, 1'b0);
    // in_valid still high on the handoff edge: no accept there
    release_result("stall");
    bus.in_valid = 1'b0;

    // Negative a: -3.0 + 1.0
    run(32'hC040_0000, 32'h3F80_0000, 1'b0, lat);
    chk("neg.latency", lat, 32'd2);
    chk_result("neg", 24'hC00000, 24'h400000, 8'h80, 1'b1, 1'b1, 1'b0);
    release_result("neg");

    // Denormal a minus normal b with equal effective exponent; b wins on mantissa
    run(32'h0000_0003, 32'h0080_0001, 1'b1, lat);
    chk("denorm.latency", lat, 32'd1);
    chk_result("denorm", 24'h800001, 24'h000003, 8'h01, 1'b1, 1'b1, 1'b0);
    release_result("denorm");

    // +Inf + 1.0: special flagged, d=0x80 takes the far path
    run(32'h7F80_0000, 32'h3F80_0000, 1'b0, lat);
    chk("inf.latency", lat, 32'd1);
    chk_result("inf", 24'h800000, 24'h000000, 8'hFF, 1'b0, 1'b0, 1'b1);
    release_result("inf");

    // Reset in the middle of SHIFT for the d=9 pair
    @(negedge clk);
    bus.a        = 32'h4400_0000;
    bus.b        = 32'h3F80_0000;
    bus.op       = 1'b0;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst.out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("midrst.in_ready",  {31'd0, bus.in_ready},  32'd1);
    chk_result("midrst", 24'h0, 24'h0, 8'h00, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rstn = 1'b1;
    seen_valid = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (bus.out_valid === 1'b1) seen_valid = seen_valid + 1;
    end
    chk("midrst.no_valid", seen_valid, 32'd0);
    chk("midrst.idle", {31'd0, bus.in_ready}, 32'd1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
